// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Raster/sync bundle from vga_timing_gen to the colour pipeline and the VGA connector.
interface vga_timing_gen_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        hs;
   logic        vs;
   logic        frame_start;
   logic [15:0] frame_count;

   modport master (
      output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
   );

   modport slave (
      input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// 640x480@60Hz VGA raster timing: registered DrawX/DrawY/blank/frame_start, hs/vs delayed SYNC_DELAY clocks.
// Optional macro VGA_FRAME_COUNT_EN enables the 16-bit frame_count register (otherwise tied to zero).
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned SYNC_DELAY = 2
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
   localparam logic [10:0] H_SS_L   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SE_L   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST_L = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
   localparam logic [10:0] V_SS_L   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SE_L   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] V_LAST_L = 11'(V_TOTAL - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (SYNC_DELAY > 7) begin : g_delay_check
      $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
   end

   logic [9:0]  hc_q, hc_d, vc_q, vc_d;
   logic [10:0] hc_x, vc_x;
   logic [9:0]  drawx_q, drawy_q;
   logic        blank_q, blank_d;
   logic        frame_start_q, frame_start_d;
   logic        hs_raw, vs_raw;
   logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

   assign hc_x = {1'b0, hc_q};
   assign vc_x = {1'b0, vc_q};

   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_x == H_LAST_L) begin
         hc_d = '0;
         vc_d = (vc_x == V_LAST_L) ? '0 : vc_q + 10'd1;
      end
      blank_d       = (hc_x < H_ACT_L) && (vc_x < V_ACT_L);
      hs_raw        = !((hc_x >= H_SS_L) && (hc_x < H_SE_L));
      vs_raw        = !((vc_x >= V_SS_L) && (vc_x < V_SE_L));
      frame_start_d = (hc_q == '0) && (vc_q == '0);
   end

   // Stage 0 matches DrawX latency; the remaining SYNC_DELAY stages are the extra delay.
   if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_pipe_d = hs_raw;
      assign vs_pipe_d = vs_raw;
   end else begin : g_delay
      assign hs_pipe_d = {hs_pipe_q[SYNC_DELAY-1:0], hs_raw};
      assign vs_pipe_d = {vs_pipe_q[SYNC_DELAY-1:0], vs_raw};
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q          <= '0;
         vc_q          <= '0;
         drawx_q       <= '0;
         drawy_q       <= '0;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         hs_pipe_q     <= '1;
         vs_pipe_q     <= '1;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         drawx_q       <= hc_q;
         drawy_q       <= vc_q;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
      end
   end

   assign vga.DrawX       = drawx_q;
   assign vga.DrawY       = drawy_q;
   assign vga.blank       = blank_q;
   assign vga.frame_start = frame_start_q;
   assign vga.hs          = hs_pipe_q[SYNC_DELAY];
   assign vga.vs          = vs_pipe_q[SYNC_DELAY];

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count_q;

   // Counts on the same edge that registers frame_start high.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)          frame_count_q <= '0;
      else if (frame_start_d) frame_count_q <= frame_count_q + 16'd1;
   end

   assign vga.frame_count = frame_count_q;
`else
   assign vga.frame_count = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Self-checking bench for vga_timing_gen: two reduced-geometry instances (delay 0 and 2) plus one default 640x480 instance.
module tb_vga_timing_gen;
   localparam int unsigned SH_A = 16, SH_FP = 4, SH_S = 6, SH_BP = 6;
   localparam int unsigned SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 3;

   typedef struct {
      int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, d;
   } geom_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   always #20 vga_clk = ~vga_clk;

   vga_timing_gen_if if_s ();
   vga_timing_gen_if if_d ();
   vga_timing_gen_if if_f ();

   vga_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
      .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .SYNC_DELAY(0)
   ) dut_s (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_s));

   vga_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
      .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .SYNC_DELAY(2)
   ) dut_d (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d));

   vga_timing_gen #(.SYNC_DELAY(2)) dut_f (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_f));

   logic [9:0]  ax[3], ay[3];
   logic        ab[3], ahs[3], avs[3], afs[3];
   logic [15:0] afc[3];
   assign ax[0] = if_s.DrawX;  assign ax[1] = if_d.DrawX;  assign ax[2] = if_f.DrawX;
   assign ay[0] = if_s.DrawY;  assign ay[1] = if_d.DrawY;  assign ay[2] = if_f.DrawY;
   assign ab[0] = if_s.blank;  assign ab[1] = if_d.blank;  assign ab[2] = if_f.blank;
   assign ahs[0] = if_s.hs;    assign ahs[1] = if_d.hs;    assign ahs[2] = if_f.hs;
   assign avs[0] = if_s.vs;    assign avs[1] = if_d.vs;    assign avs[2] = if_f.vs;
   assign afs[0] = if_s.frame_start; assign afs[1] = if_d.frame_start; assign afs[2] = if_f.frame_start;
   assign afc[0] = if_s.frame_count; assign afc[1] = if_d.frame_count; assign afc[2] = if_f.frame_count;

   int     checks = 0;
   int     errors = 0;
   longint k;        // rising edges since reset release; output at edge k shows raster time c = k-1
   geom_t  g[3];

   // Reference model: raster position as a pure function of elapsed clocks since release.
   function automatic longint htot(geom_t gg);
      return longint'(gg.ha + gg.hfp + gg.hsw + gg.hbp);
   endfunction
   function automatic longint vtot(geom_t gg);
      return longint'(gg.va + gg.vfp + gg.vsw + gg.vbp);
   endfunction
   function automatic longint m_hc(geom_t gg, longint c);
      return c % htot(gg);
   endfunction
   function automatic longint m_vc(geom_t gg, longint c);
      return (c / htot(gg)) % vtot(gg);
   endfunction
   function automatic logic m_blank(geom_t gg, longint c);
      return (m_hc(gg, c) < longint'(gg.ha)) && (m_vc(gg, c) < longint'(gg.va));
   endfunction
   function automatic logic m_hs(geom_t gg, longint c);
      longint h;
      if (c < longint'(gg.d)) return 1'b1;
      h = m_hc(gg, c - longint'(gg.d));
      return !(h >= longint'(gg.ha + gg.hfp) && h < longint'(gg.ha + gg.hfp + gg.hsw));
   endfunction
   function automatic logic m_vs(geom_t gg, longint c);
      longint v;
      if (c < longint'(gg.d)) return 1'b1;
      v = m_vc(gg, c - longint'(gg.d));
      return !(v >= longint'(gg.va + gg.vfp) && v < longint'(gg.va + gg.vfp + gg.vsw));
   endfunction
   function automatic logic m_fs(geom_t gg, longint c);
      return (c % (htot(gg) * vtot(gg))) == 0;
   endfunction
   function automatic logic [15:0] m_fc(geom_t gg, longint c);
`ifdef VGA_FRAME_COUNT_EN
      return 16'(c / (htot(gg) * vtot(gg)) + 1);
`else
      return 16'(0 * c * htot(gg));
`endif
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      #1;
      k = k + 1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      k = 0;
      repeat (10) @(posedge vga_clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]} !==
             {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_hold inst%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d required 0 0 0 1 1 0 0",
                     i, ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]);
         end
      end
      @(negedge vga_clk);
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i]} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1} ||
             afc[i] !== m_fc(g[i], 0)) begin
            errors++;
            $display("FAIL first_edge inst%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d required 0 0 1 1 1 1 %0d",
                     i, ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i], m_fc(g[i], 0));
         end
      end
   endtask

   task automatic test_line_sweep();
      longint stop = 1602 + longint'($urandom_range(0, 60));
      int hs_low = 0;
      int act = 0;
      longint c;
      while (k < stop) begin
         tick();
         c = k - 1;
         for (int i = 0; i < 3; i += 2) begin
            checks++;
            if ({ax[i], ay[i], ab[i], ahs[i]} !==
                {10'(m_hc(g[i], c)), 10'(m_vc(g[i], c)), m_blank(g[i], c), m_hs(g[i], c)}) begin
               errors++;
               $display("FAIL line_sweep inst%0d c=%0d got x=%0d y=%0d blank=%b hs=%b required %0d %0d %b %b",
                        i, c, ax[i], ay[i], ab[i], ahs[i],
                        m_hc(g[i], c), m_vc(g[i], c), m_blank(g[i], c), m_hs(g[i], c));
            end
         end
         if (c >= 800 && c < 1600) begin
            if (ahs[2] === 1'b0) hs_low++;
            if (ab[2] === 1'b1) act++;
         end
      end
      checks++;
      if (hs_low != 96) begin
         errors++;
         $display("FAIL hs_width got %0d low clocks required 96", hs_low);
      end
      checks++;
      if (act != 640) begin
         errors++;
         $display("FAIL active_width got %0d blank-high clocks required 640", act);
      end
   endtask

   task automatic test_full_frame();
      longint frame = htot(g[0]) * vtot(g[0]);
      longint stop = k + 2 * frame + longint'($urandom_range(0, 100));
      longint last_fs = -1;
      int vs_run = (avs[0] === 1'b0) ? -1 : 0;
      longint c;
      while (k < stop) begin
         tick();
         c = k - 1;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ax[i], ay[i], ab[i], avs[i], afs[i], afc[i]} !==
                {10'(m_hc(g[i], c)), 10'(m_vc(g[i], c)), m_blank(g[i], c), m_vs(g[i], c), m_fs(g[i], c), m_fc(g[i], c)}) begin
               errors++;
               $display("FAIL full_frame inst%0d c=%0d got x=%0d y=%0d blank=%b vs=%b fs=%b fc=%0d required %0d %0d %b %b %b %0d",
                        i, c, ax[i], ay[i], ab[i], avs[i], afs[i], afc[i], m_hc(g[i], c), m_vc(g[i], c),
                        m_blank(g[i], c), m_vs(g[i], c), m_fs(g[i], c), m_fc(g[i], c));
            end
         end
         if (afs[0] === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (k - last_fs != frame) begin
                  errors++;
                  $display("FAIL fs_period got %0d clocks required %0d", k - last_fs, frame);
               end
            end
            last_fs = k;
         end
         if (avs[0] === 1'b0) begin
            if (vs_run >= 0) vs_run++;
         end else begin
            if (vs_run > 0) begin
               checks++;
               if (vs_run != int'(SV_S * htot(g[0]))) begin
                  errors++;
                  $display("FAIL vs_width got %0d clocks required %0d", vs_run, SV_S * htot(g[0]));
               end
            end
            vs_run = 0;
         end
      end
   endtask

   task automatic test_sync_delay();
      longint stop = k + 900 + longint'($urandom_range(0, 200));
      logic prev[3];
      int nfall = 0;
      longint c;
      for (int i = 0; i < 3; i++) prev[i] = ahs[i];
      while (k < stop) begin
         tick();
         c = k - 1;
         checks++;
         if ({ax[1], ab[1], ahs[1], avs[1]} !==
             {10'(m_hc(g[1], c)), m_blank(g[1], c), m_hs(g[1], c), m_vs(g[1], c)}) begin
            errors++;
            $display("FAIL sync_delay c=%0d got x=%0d blank=%b hs=%b vs=%b required %0d %b %b %b",
                     c, ax[1], ab[1], ahs[1], avs[1], m_hc(g[1], c), m_blank(g[1], c), m_hs(g[1], c), m_vs(g[1], c));
         end
         for (int i = 1; i < 3; i++) begin
            if (prev[i] === 1'b1 && ahs[i] === 1'b0) begin
               if (i == 2) nfall++;
               checks++;
               if (longint'(ax[i]) != (longint'(g[i].ha + g[i].hfp + g[i].d) % htot(g[i]))) begin
                  errors++;
                  $display("FAIL hs_fall inst%0d at DrawX=%0d required %0d", i, ax[i],
                           (g[i].ha + g[i].hfp + g[i].d) % htot(g[i]));
               end
            end
            if (prev[i] === 1'b0 && ahs[i] === 1'b1) begin
               checks++;
               if (longint'(ax[i]) != (longint'(g[i].ha + g[i].hfp + g[i].hsw + g[i].d) % htot(g[i]))) begin
                  errors++;
                  $display("FAIL hs_rise inst%0d at DrawX=%0d required %0d", i, ax[i],
                           (g[i].ha + g[i].hfp + g[i].hsw + g[i].d) % htot(g[i]));
               end
            end
            prev[i] = ahs[i];
         end
      end
      checks++;
      if (nfall < 1) begin
         errors++;
         $display("FAIL hs_fall_seen got %0d falling edges required at least 1", nfall);
      end
   endtask

   task automatic test_mid_reset();
      int hold = int'($urandom_range(1, 4));
      longint c;
      repeat ($urandom_range(50, 400)) tick();
      #5;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]} !==
             {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL async_reset inst%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d required 0 0 0 1 1 0 0",
                     i, ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]);
         end
      end
      repeat (hold) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      k = 0;
      repeat (40) begin
         tick();
         c = k - 1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]} !==
                {10'(m_hc(g[i], c)), 10'(m_vc(g[i], c)), m_blank(g[i], c), m_hs(g[i], c), m_vs(g[i], c),
                 m_fs(g[i], c), m_fc(g[i], c)}) begin
               errors++;
               $display("FAIL restart inst%0d c=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
                        i, c, ax[i], ay[i], ab[i], ahs[i], avs[i], afs[i], afc[i]);
            end
         end
      end
   endtask

   task automatic test_frame_count();
      longint frame = htot(g[0]) * vtot(g[0]);
      longint c;
      while (k < 3 * frame) begin
         tick();
         c = k - 1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (afc[i] !== m_fc(g[i], c)) begin
               errors++;
               $display("FAIL frame_count inst%0d c=%0d got %0d required %0d", i, c, afc[i], m_fc(g[i], c));
            end
         end
      end
`ifdef VGA_FRAME_COUNT_EN
      checks++;
      if (afc[0] !== 16'd3) begin
         errors++;
         $display("FAIL three_frames got %0d required 3", afc[0]);
      end
      force dut_s.frame_count_q = 16'hFFFF;
      #1;
      release dut_s.frame_count_q;
      begin
         int n = 0;
         do begin
            tick();
            n++;
         end while (afs[0] !== 1'b1 && n < 700);
         checks++;
         if (afs[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_timeout no frame_start within %0d clocks required 1 pulse", n);
         end else if (afc[0] !== 16'h0000) begin
            errors++;
            $display("FAIL frame_count_wrap got %0h required 0", afc[0]);
         end
      end
`else
      checks++;
      if (afc[0] !== 16'd0 || afc[2] !== 16'd0) begin
         errors++;
         $display("FAIL frame_count_tied got %0d/%0d required 0", afc[0], afc[2]);
      end
`endif
   endtask

   initial begin
      g[0] = '{SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 0};
      g[1] = '{SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 2};
      g[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
      test_reset();
      test_line_sweep();
      test_full_frame();
      test_sync_delay();
      test_mid_reset();
      test_frame_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation exceeded 2 ms");
      $fatal(1, "watchdog");
   end
endmodule
